// File: rtl/axis_endec_bridge.sv
// AXI-Stream front end for the convolutional encoder/decoder core: accepts a header and a payload,
// packs the payload into the core frame, sequences core reset/enable, and streams the result out MSB-first.
module axis_endec_bridge #(
  parameter int DATA_W      = 32,
  parameter int ENC_IN_W    = 128,
  parameter int ENC_OUT_W   = 384,
  parameter int POLY_W      = 27,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  output logic [DATA_W-1:0]    m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 o_core_rst_n,
  output logic                 o_core_en,
  output logic                 o_mode,
  output logic                 o_code_rate,
  output logic                 o_constr_len,
  output logic [POLY_W-1:0]    o_gen_poly,
  output logic [ENC_IN_W-1:0]  o_enc_frame,
  output logic [ENC_OUT_W-1:0] o_dec_frame,
  input  logic [ENC_OUT_W-1:0] i_enc_data,
  input  logic                 i_enc_done,
  input  logic [ENC_IN_W-1:0]  i_dec_data,
  input  logic                 i_dec_done,
  output logic                 o_err_len,
  output logic                 o_err_timeout
);
  localparam int ENC_BEATS = ENC_IN_W / DATA_W;
  localparam int DEC_BEATS = ENC_OUT_W / DATA_W;
  localparam int MAX_BEATS = (DEC_BEATS > ENC_BEATS) ? DEC_BEATS : ENC_BEATS;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);
  localparam int WAIT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam int SR_W      = (ENC_OUT_W > ENC_IN_W) ? ENC_OUT_W : ENC_IN_W;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_START, S_WAIT, S_SEND} state_t;
  state_t state_reg, state_next;

  logic s_ready_reg, m_valid_reg, core_rst_n_reg, core_en_reg;
  logic s_ready_next, m_valid_next, core_rst_n_next, core_en_next;
  logic mode_reg, code_rate_reg, constr_len_reg;
  logic [POLY_W-1:0] poly_reg;
  logic err_len_reg, err_timeout_reg;
  logic [CNT_W-1:0] beat_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [SR_W-1:0] out_sr_reg;

  logic s_fire, m_fire, core_done, in_last_beat, out_last_beat, timeout_hit, hdr_accept, load_fire;

  assign s_fire        = s_axis_tvalid && s_ready_reg;
  assign m_fire        = m_valid_reg && m_axis_tready;
  assign core_done     = mode_reg ? i_dec_done : i_enc_done;
  assign in_last_beat  = beat_cnt_reg == (mode_reg ? CNT_W'(DEC_BEATS - 1) : CNT_W'(ENC_BEATS - 1));
  assign out_last_beat = beat_cnt_reg == (mode_reg ? CNT_W'(ENC_BEATS - 1) : CNT_W'(DEC_BEATS - 1));
  assign timeout_hit   = wait_cnt_reg == WAIT_W'(TIMEOUT_CYC - 1);
  assign hdr_accept    = s_fire && (state_reg == S_IDLE);
  assign load_fire     = s_fire && (state_reg == S_LOAD);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (s_fire && !s_axis_tlast) state_next = S_LOAD;
      S_LOAD:  if (s_fire) begin
                 if (s_axis_tlast)      state_next = S_START;
                 else if (in_last_beat) state_next = S_DRAIN;
               end
      S_DRAIN: if (s_fire && s_axis_tlast) state_next = S_START;
      S_START: state_next = S_WAIT;
      S_WAIT:  if (core_done)        state_next = S_SEND;
               else if (timeout_hit) state_next = S_IDLE;
      S_SEND:  if (m_fire && out_last_beat) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake/control outputs are registered from the next state so they are glitch-free
  // and tready only rises one cycle after reset release.
  always_comb begin
    s_ready_next    = 1'b0;
    m_valid_next    = 1'b0;
    core_rst_n_next = 1'b1;
    core_en_next    = 1'b0;
    case (state_next)
      S_IDLE, S_LOAD, S_DRAIN: s_ready_next = 1'b1;
      S_START: core_rst_n_next = 1'b0;
      S_WAIT:  core_en_next = 1'b1;
      S_SEND: begin
        core_en_next = 1'b1;
        m_valid_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      s_ready_reg    <= 1'b0;
      m_valid_reg    <= 1'b0;
      core_rst_n_reg <= 1'b1;
      core_en_reg    <= 1'b0;
    end else begin
      s_ready_reg    <= s_ready_next;
      m_valid_reg    <= m_valid_next;
      core_rst_n_reg <= core_rst_n_next;
      core_en_reg    <= core_en_next;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      mode_reg        <= 1'b0;
      code_rate_reg   <= 1'b0;
      constr_len_reg  <= 1'b0;
      poly_reg        <= '0;
      err_len_reg     <= 1'b0;
      err_timeout_reg <= 1'b0;
      beat_cnt_reg    <= '0;
      wait_cnt_reg    <= '0;
      out_sr_reg      <= '0;
    end else begin
      if (hdr_accept) begin
        mode_reg        <= s_axis_tdata[29];
        code_rate_reg   <= s_axis_tdata[28];
        constr_len_reg  <= s_axis_tdata[27];
        poly_reg        <= s_axis_tdata[POLY_W-1:0];
        err_len_reg     <= 1'b0;
        err_timeout_reg <= 1'b0;
      end
      // A length error is either an early tlast or a missing tlast on the final expected beat.
      if (load_fire && (s_axis_tlast != in_last_beat)) err_len_reg <= 1'b1;
      if (state_reg == S_WAIT && !core_done && timeout_hit) err_timeout_reg <= 1'b1;

      if (hdr_accept || (state_reg == S_WAIT && core_done)) beat_cnt_reg <= '0;
      else if (load_fire || m_fire)                         beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);

      wait_cnt_reg <= (state_reg == S_WAIT) ? wait_cnt_reg + WAIT_W'(1) : '0;

      if (state_reg == S_WAIT && core_done)
        out_sr_reg <= mode_reg ? (SR_W'(i_dec_data) << (SR_W - ENC_IN_W))
                               : (SR_W'(i_enc_data) << (SR_W - ENC_OUT_W));
      else if (m_fire)
        out_sr_reg <= out_sr_reg << DATA_W;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENC_BEATS; gi++) begin : g_enc_word
      logic [DATA_W-1:0] word_reg;
      always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)             word_reg <= '0;
        else if (hdr_accept) word_reg <= '0;
        else if (load_fire && !mode_reg && beat_cnt_reg == CNT_W'(gi)) word_reg <= s_axis_tdata;
      end
      assign o_enc_frame[ENC_IN_W-1-gi*DATA_W -: DATA_W] = word_reg;
    end
    for (gi = 0; gi < DEC_BEATS; gi++) begin : g_dec_word
      logic [DATA_W-1:0] word_reg;
      always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)             word_reg <= '0;
        else if (hdr_accept) word_reg <= '0;
        else if (load_fire && mode_reg && beat_cnt_reg == CNT_W'(gi)) word_reg <= s_axis_tdata;
      end
      assign o_dec_frame[ENC_OUT_W-1-gi*DATA_W -: DATA_W] = word_reg;
    end
  endgenerate

  assign s_axis_tready = s_ready_reg;
  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tdata  = out_sr_reg[SR_W-1 -: DATA_W];
  assign m_axis_tlast  = m_valid_reg && out_last_beat;
  assign o_core_rst_n  = core_rst_n_reg;
  assign o_core_en     = core_en_reg;
  assign o_mode        = mode_reg;
  assign o_code_rate   = code_rate_reg;
  assign o_constr_len  = constr_len_reg;
  assign o_gen_poly    = poly_reg;
  assign o_err_len     = err_len_reg;
  assign o_err_timeout = err_timeout_reg;
endmodule

// File: tb/tb_axis_endec_bridge.sv
// Randomised bench for axis_endec_bridge: a queue-based model of packing, result slicing and
// handshake timing, checked every cycle by an output monitor plus per-transaction checks.
module tb_axis_endec_bridge;
  localparam int DW = 32;
  localparam int IW = 128;
  localparam int OW = 384;
  localparam int PW = 27;
  localparam int TO = 4096;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          o_core_rst_n, o_core_en, o_mode, o_code_rate, o_constr_len;
  logic [PW-1:0] o_gen_poly;
  logic [IW-1:0] o_enc_frame;
  logic [OW-1:0] o_dec_frame;
  logic [OW-1:0] i_enc_data = '0;
  logic          i_enc_done = 1'b0;
  logic [IW-1:0] i_dec_data = '0;
  logic          i_dec_done = 1'b0;
  logic          o_err_len, o_err_timeout;

  axis_endec_bridge #(.DATA_W(DW), .ENC_IN_W(IW), .ENC_OUT_W(OW), .POLY_W(PW), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .o_core_rst_n(o_core_rst_n), .o_core_en(o_core_en), .o_mode(o_mode), .o_code_rate(o_code_rate),
    .o_constr_len(o_constr_len), .o_gen_poly(o_gen_poly), .o_enc_frame(o_enc_frame),
    .o_dec_frame(o_dec_frame), .i_enc_data(i_enc_data), .i_enc_done(i_enc_done),
    .i_dec_data(i_dec_data), .i_dec_done(i_dec_done), .o_err_len(o_err_len),
    .o_err_timeout(o_err_timeout)
  );

  always #5 sys_clk = ~sys_clk;

  int total_cnt = 0;
  int pass_cnt = 0;
  int beats_seen = 0;
  int rdy_mode = 0;
  logic [31:0] exp_q[$];
  bit          last_q[$];
  logic [31:0] pay[16];

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Output sink: 0 = always ready, 1 = random, 2 = never ready.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      case (rdy_mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = 1'($urandom_range(0, 1));
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Every valid output cycle must match the head of the expected queue; stalls must hold the head.
  always @(negedge sys_clk) begin
    if (!rst && m_axis_tvalid) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL out_unexpected: got beat %0h, required no beat", m_axis_tdata);
      end else begin
        chk("out_data", m_axis_tdata, exp_q[0]);
        chk("out_last", m_axis_tlast, last_q[0]);
        if (m_axis_tready) begin
          void'(exp_q.pop_front());
          void'(last_q.pop_front());
          beats_seen++;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [31:0] d, input bit last);
    int guard = 0;
    repeat ($urandom_range(0, 2)) begin @(posedge sys_clk); #1; end
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    do begin @(negedge sys_clk); guard++; end while (!s_axis_tready && guard < 50);
    if (!s_axis_tready) begin
      total_cnt++;
      $display("FAIL in_handshake: got tready 0, required 1");
    end
    @(posedge sys_clk); #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] hdr, input int n);
    send_beat(hdr, n == 0);
    for (int k = 0; k < n; k++) send_beat(pay[k], k == n - 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ctl"}, {s_axis_tready, m_axis_tvalid, m_axis_tlast, o_core_rst_n, o_core_en, o_mode,
                        o_code_rate, o_constr_len, o_err_len, o_err_timeout}, 10'b0001000000);
    chk({tag, "_poly_data"}, {o_gen_poly, m_axis_tdata}, 0);
    chk({tag, "_enc_frame"}, o_enc_frame, 0);
    chk({tag, "_dec_frame"}, o_dec_frame, 0);
  endtask

  // delay < 0 means the core never finishes.
  task automatic run_txn(input logic [31:0] hdr, input int n, input int delay, input int rmode);
    logic [383:0] res_enc, tmp;
    logic [127:0] res_dec;
    bit mode;
    int in_b, out_b, used, guard, cnt, seen0;
    mode  = hdr[29];
    in_b  = mode ? 12 : 4;
    out_b = mode ? 4 : 12;
    rdy_mode = rmode;
    res_enc = '0;
    res_dec = '0;
    for (int i = 0; i < 12; i++) res_enc = {res_enc[351:0], 32'($urandom)};
    for (int i = 0; i < 4; i++)  res_dec = {res_dec[95:0], 32'($urandom)};
    i_enc_data = res_enc;
    i_dec_data = res_dec;
    i_enc_done = 1'b0;
    i_dec_done = 1'b0;
    send_pkt(hdr, n);
    guard = 0;
    while (o_core_rst_n && guard < 20) begin @(negedge sys_clk); guard++; end
    if (o_core_rst_n) begin
      total_cnt++;
      $display("FAIL core_rst_wait: got o_core_rst_n 1, required a low pulse");
      return;
    end
    used = (n < in_b) ? n : in_b;
    tmp = '0;
    for (int k = 0; k < used; k++) tmp = (tmp << 32) | 384'(pay[k]);
    tmp = tmp << (32 * (in_b - used));
    if (mode) begin
      chk("dec_frame", o_dec_frame, tmp);
      chk("enc_frame_clr", o_enc_frame, 0);
    end else begin
      chk("enc_frame", o_enc_frame, tmp[127:0]);
      chk("dec_frame_clr", o_dec_frame, 0);
    end
    chk("err_len", o_err_len, n != in_b);
    chk("config", {o_mode, o_code_rate, o_constr_len, o_gen_poly}, hdr[29:0]);
    chk("err_timeout_clr", o_err_timeout, 0);
    @(posedge sys_clk); #1;
    chk("core_rst_pulse", {o_core_rst_n, o_core_en}, 2'b11);
    // The done flag of the unselected direction must be ignored.
    if (mode) i_enc_done = 1'b1; else i_dec_done = 1'b1;
    if (delay < 0) begin
      cnt = 0;
      while (o_core_en && cnt < TO + 100) begin cnt++; @(posedge sys_clk); #1; end
      chk("timeout_cycles", cnt, TO);
      chk("err_timeout", o_err_timeout, 1);
      chk("ready_after_timeout", s_axis_tready, 1);
      i_enc_done = 1'b0;
      i_dec_done = 1'b0;
      return;
    end
    repeat (delay) begin @(posedge sys_clk); #1; end
    tmp = mode ? {res_dec, 256'b0} : res_enc;
    for (int j = 0; j < out_b; j++) begin
      exp_q.push_back(tmp[383:352]);
      last_q.push_back(j == out_b - 1);
      tmp = tmp << 32;
    end
    seen0 = beats_seen;
    if (mode) i_dec_done = 1'b1; else i_enc_done = 1'b1;
    @(negedge sys_clk);
    chk("latency_pre", m_axis_tvalid, 0);
    @(negedge sys_clk);
    chk("latency_valid", {m_axis_tvalid, o_core_en}, 2'b11);
    guard = 0;
    while (!(exp_q.size() == 0 && s_axis_tready) && guard < 1000) begin @(negedge sys_clk); guard++; end
    chk("out_beats", beats_seen - seen0, out_b);
    chk("valid_after_send", {m_axis_tvalid, o_core_en}, 0);
    chk("ready_after_send", s_axis_tready, 1);
    @(posedge sys_clk); #1;
    i_enc_done = 1'b0;
    i_dec_done = 1'b0;
  endtask

  task automatic hdr_only(input logic [31:0] hdr);
    bit low_seen, busy_seen;
    send_beat(hdr, 1'b1);
    low_seen  = 1'b0;
    busy_seen = 1'b0;
    repeat (10) begin
      @(negedge sys_clk);
      if (!o_core_rst_n) low_seen = 1'b1;
      if (!s_axis_tready || m_axis_tvalid || o_core_en) busy_seen = 1'b1;
    end
    chk("hdr_only_no_core_rst", low_seen, 0);
    chk("hdr_only_idle", busy_seen, 0);
    chk("hdr_only_config", {o_mode, o_code_rate, o_constr_len, o_gen_poly}, hdr[29:0]);
    chk("hdr_only_err_clr", {o_err_len, o_err_timeout}, 0);
    chk("hdr_only_frames_clr", (o_enc_frame == 0) && (o_dec_frame == 0), 1);
    @(posedge sys_clk); #1;
  endtask

  task automatic reset_mid_send();
    logic [383:0] res, tmp;
    int guard;
    res = '0;
    for (int i = 0; i < 12; i++) res = {res[351:0], 32'($urandom)};
    for (int k = 0; k < 4; k++) pay[k] = $urandom;
    i_enc_data = res;
    rdy_mode = 2;
    send_pkt(32'h0000_1234, 4);
    guard = 0;
    while (o_core_rst_n && guard < 20) begin @(negedge sys_clk); guard++; end
    @(posedge sys_clk); #1;
    tmp = res;
    for (int j = 0; j < 12; j++) begin
      exp_q.push_back(tmp[383:352]);
      last_q.push_back(j == 11);
      tmp = tmp << 32;
    end
    i_enc_done = 1'b1;
    guard = 0;
    while (!m_axis_tvalid && guard < 20) begin @(negedge sys_clk); guard++; end
    chk("mid_send_valid", m_axis_tvalid, 1);
    repeat (3) @(negedge sys_clk);
    #2 rst = 1'b1;
    #1 chk_reset("rst_mid_send");
    exp_q.delete();
    last_q.delete();
    i_enc_done = 1'b0;
    @(negedge sys_clk);
    rst = 1'b0;
    #1 chk("rst_release_ready_low", s_axis_tready, 0);
    @(posedge sys_clk); #1;
    chk("rst_release_idle", {s_axis_tready, m_axis_tvalid}, 2'b10);
    rdy_mode = 0;
  endtask

  initial begin
    logic [31:0] hdr;
    int in_b, n, sel;
    repeat (3) @(posedge sys_clk);
    #1 chk_reset("reset");
    @(negedge sys_clk);
    rst = 1'b0;
    #1 chk("ready_at_release", s_axis_tready, 0);
    @(posedge sys_clk); #1;
    chk("ready_after_release", s_axis_tready, 1);

    // Encode with a fixed payload.
    pay[0] = 32'hA5A5_A5A5; pay[1] = 32'h0; pay[2] = 32'h0; pay[3] = 32'hFFFF_FFFF;
    run_txn({5'b00000, 27'h4B5_1F3}, 4, 20, 0);
    chk("enc_frame_literal", o_enc_frame, 128'hA5A5A5A5_00000000_00000000_FFFFFFFF);

    // Decode, 12 beats, random backpressure, done already high on first WAIT cycle.
    for (int k = 0; k < 12; k++) pay[k] = 32'h1000_0000 + 32'(k);
    run_txn(32'h3800_0ABC, 12, 0, 1);
    chk("dec_frame_first_literal", o_dec_frame[383:352], 32'h1000_0000);
    chk("dec_frame_last_literal", o_dec_frame[31:0], 32'h1000_000B);

    // Short encode packet.
    for (int k = 0; k < 16; k++) pay[k] = $urandom;
    run_txn(32'h0800_0123, 2, 3, 1);
    chk("short_low_zero", o_enc_frame[63:0], 0);
    chk("short_err_len", o_err_len, 1);

    // Long encode packet: beats beyond the fourth are dropped.
    for (int k = 0; k < 6; k++) pay[k] = 32'(32'h1111_1111 * (k + 1));
    run_txn(32'h1000_0777, 6, 7, 0);
    chk("long_frame_literal", o_enc_frame, 128'h11111111_22222222_33333333_44444444);
    chk("long_err_len", o_err_len, 1);

    hdr_only(32'h2C12_3456);

    for (int t = 0; t < 12; t++) begin
      hdr = $urandom;
      in_b = hdr[29] ? 12 : 4;
      sel = int'($urandom_range(0, 3));
      if (sel == 1)      n = int'($urandom_range(1, in_b - 1));
      else if (sel == 2) n = in_b + int'($urandom_range(1, 3));
      else               n = in_b;
      for (int k = 0; k < 16; k++) pay[k] = $urandom;
      run_txn(hdr, n, int'($urandom_range(0, 25)), int'($urandom_range(0, 1)));
    end

    for (int k = 0; k < 16; k++) pay[k] = $urandom;
    run_txn(32'h0000_0042, 4, -1, 0);
    run_txn(32'h2000_0042, 12, 4, 1);

    reset_mid_send();
    for (int k = 0; k < 16; k++) pay[k] = $urandom;
    run_txn(32'h1800_0FED, 4, 2, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/axis_endec_bridge.md
Name: axis_endec_bridge

Overview:
Parametrised AXI-Stream front end for the convolutional encoder/decoder core (endec). It accepts a header beat followed by a payload packet on a slave stream and packs the payload MSB-first into the core's input frame. It then pulses the core reset, waits for the core's done flag, and streams the result MSB-first on a master stream. It adds the following:
- generic data and frame widths;
- config-only packets;
- length-error handling with drain;
- backpressure-safe output;
- a core timeout.

Parameters:
DATA_W, 32, stream beat width; must be ≥ 30; both frame widths must be integer multiples of it
ENC_IN_W, 128, encoder input / decoder output frame width
ENC_OUT_W, 384, encoder output / decoder input frame width
POLY_W, 27, flattened generator polynomial width (header bits 26:0)
TIMEOUT_CYC, 4096, maximum number of cycles in WAIT before abort

Ports:
sys_clk  in  1  clock
rst  in  1  asynchronous active-high reset
s_axis_tdata  in  DATA_W  input beat
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last input beat of packet
m_axis_tdata  out  DATA_W  output beat
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  last output beat
o_core_rst_n  out  1  core synchronous reset, low = reset
o_core_en  out  1  core enable
o_mode  out  1  0 = encode, 1 = decode
o_code_rate  out  1  latched header bit 28
o_constr_len  out  1  latched header bit 27
o_gen_poly  out  POLY_W  latched header bits 26:0
o_enc_frame  out  ENC_IN_W  packed encoder input
o_dec_frame  out  ENC_OUT_W  packed decoder input
i_enc_data  in  ENC_OUT_W  core encoder result
i_enc_done  in  1  core encoder done
i_dec_data  in  ENC_IN_W  core decoder result
i_dec_done  in  1  core decoder done
o_err_len  out  1  sticky: payload length mismatch on the current packet
o_err_timeout  out  1  sticky: core did not finish

Behaviour:
- Reset (asynchronous, rst = 1):
  - State goes to IDLE.
  - Outputs cleared: every output 0 except o_core_rst_n = 1. s_axis_tready = 0, m_axis_tvalid = 0, all frames 0, both error flags 0.
  - s_axis_tready rises in the first cycle after reset is released.
  - Reset asserted mid-operation aborts immediately; no partial output is emitted.
- Handshake rules:
  - A beat transfers on a clock edge where tvalid && tready.
  - While m_axis_tvalid = 1 and m_axis_tready = 0, m_axis_tdata and m_axis_tlast hold stable.
- Beat counts:
  - IN_BEATS = ENC_IN_W/DATA_W in encode mode (4 at defaults), or ENC_OUT_W/DATA_W in decode mode (12).
  - OUT_BEATS is the opposite count.
- Packing: payload beat k (k = 0 first) writes frame bits [W-1-k*DATA_W -: DATA_W], where W is the width of the frame being filled.
- IDLE (s_axis_tready = 1):
  - On a header beat: latch bits 29..27 and 26:0, clear both error flags and both frames.
  - Header with tlast = 1: config-only; stay in IDLE.
  - Header with tlast = 0: go to LOAD.
- LOAD (s_axis_tready = 1):
  - Each beat is packed and increments the beat counter.
  - tlast on beat IN_BEATS-1: go to START.
  - tlast before IN_BEATS beats: set o_err_len, leave the unwritten bits 0, go to START.
  - IN_BEATS beats received without tlast: set o_err_len, go to DRAIN.
- DRAIN (s_axis_tready = 1): discard beats until a tlast beat, then go to START.
- START (s_axis_tready = 0): o_core_rst_n = 0 for exactly one cycle, then go to WAIT.
- WAIT:
  - o_core_en = 1; the done flag is selected by o_mode.
  - First cycle with done = 1: capture the result into the output shift register, go to SEND.
  - A done flag already high in the first WAIT cycle is valid.
  - Cycle counter reaches TIMEOUT_CYC: set o_err_timeout, emit nothing, go to IDLE.
- SEND:
  - m_axis_tvalid = 1; shift out MSB-first.
  - m_axis_tlast = 1 on beat OUT_BEATS-1.
  - Final handshake: m_axis_tvalid = 0 next cycle, go to IDLE, s_axis_tready = 1 next cycle.
  - o_core_en stays 1 until IDLE.
- Config outputs are stable from header acceptance until the next header.
- Error flags persist until the next header is accepted.
- Latency: the first m_axis_tvalid is asserted 1 cycle after the cycle in which WAIT sees done.
- Input is never accepted outside IDLE, LOAD and DRAIN.

Test Plan:
1. Encode: header 0x0000_0000 | poly, payload 4 beats 0xA5A5_A5A5, 0x0, 0x0, 0xFFFF_FFFF with tlast on beat 4 → o_enc_frame = {A5A5A5A5, 0, 0, FFFFFFFF}; o_core_rst_n low for 1 cycle; model done after 20 cycles → 12 output beats, MSB-first, tlast on beat 12.
2. Decode (bit 29 = 1), 12 input beats → o_dec_frame packed correctly; 4 output beats; m_axis_tready toggled randomly → data stable while stalled, no beat lost or duplicated.
3. Short encode packet of 2 beats → o_err_len = 1, o_enc_frame[63:0] = 0, output still 12 beats.
4. Long encode packet of 6 beats → beats 5–6 dropped, o_err_len = 1, processing as for a 4-beat packet.
5. Header-only packet (tlast on header) → config outputs updated, no core reset pulse, no output, s_axis_tready stays 1.
6. Done never asserted → o_err_timeout = 1 after 4096 WAIT cycles, return to IDLE; separately, rst asserted mid-SEND → m_axis_tvalid = 0 immediately, IDLE after release.
